// File: rtl/control_seq_if.sv
// Sequencer bus: flags, opcode, hold and microcode write port in; control word and step out.
interface control_seq_if #(
    parameter int CTRL_W = 16,
    parameter int OP_W   = 8,
    parameter int STEPS  = 4
);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic                   zf;
    logic                   cf;
    logic [OP_W-1:0]        ireg;
    logic                   hold;
    logic                   uc_we;
    logic [OP_W+SW-1:0]     uc_addr;
    logic [CTRL_W+2:0]      uc_wdata;
    logic [CTRL_W-1:0]      ctrl;
    logic [4:0]             step;
    logic                   fetching;

    modport master (
        output zf, cf, ireg, hold, uc_we, uc_addr, uc_wdata,
        input  ctrl, step, fetching
    );

    modport slave (
        input  zf, cf, ireg, hold, uc_we, uc_addr, uc_wdata,
        output ctrl, step, fetching
    );
endinterface

// File: rtl/control_seq.sv
// Microcoded control sequencer: three fixed fetch steps, then up to STEPS
// conditional execute microsteps read from a writable microcode store.
module control_seq #(
    parameter int                 CTRL_W = 16,
    parameter int                 OP_W   = 8,
    parameter int                 STEPS  = 4,
    parameter logic [CTRL_W-1:0]  FETCH0 = CTRL_W'(1),
    parameter logic [CTRL_W-1:0]  FETCH1 = CTRL_W'(2),
    parameter logic [CTRL_W-1:0]  FETCH2 = FETCH0
) (
    input  logic            clk,
    input  logic            rst,
    control_seq_if.slave    bus
);
    localparam int SW        = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int UW        = CTRL_W + 3;
    localparam int DEPTH     = 2 ** (OP_W + SW);
    localparam int LAST_STEP = STEPS + 2;

    typedef enum logic [2:0] {
        PH_FETCH0,
        PH_FETCH1,
        PH_FETCH2,
        PH_EXEC,
        PH_ILLEGAL
    } phase_e;

    // Contents survive reset; only power-up starts them at zero (all NOPs).
    logic [UW-1:0]     ucode_mem [DEPTH] = '{default: '0};

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [4:0]        step_q, step_d;
    phase_e            phase;
    logic [SW-1:0]     exec_idx;
    logic [UW-1:0]     mword;
    logic              cond_pass;

    always_ff @(posedge clk) begin
        if (bus.uc_we && (int'(bus.uc_addr[SW-1:0]) < STEPS)) begin
            ucode_mem[bus.uc_addr] <= bus.uc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            step_q <= '0;
        end else if (!bus.hold) begin
            ctrl_q <= ctrl_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        ctrl_d    = '0;
        step_d    = '0;
        phase     = PH_ILLEGAL;
        exec_idx  = SW'(step_q - 5'd3);
        mword     = ucode_mem[{bus.ireg, exec_idx}];
        cond_pass = 1'b1;

        if (step_q == 5'd0)                 phase = PH_FETCH0;
        else if (step_q == 5'd1)            phase = PH_FETCH1;
        else if (step_q == 5'd2)            phase = PH_FETCH2;
        else if (step_q <= 5'(LAST_STEP))   phase = PH_EXEC;

        // Flags are used live on the evaluating edge, never latched.
        case (mword[UW-1 -: 2])
            2'b00:   cond_pass = 1'b1;
            2'b01:   cond_pass = bus.zf;
            2'b10:   cond_pass = bus.cf;
            default: cond_pass = !bus.zf;
        endcase

        case (phase)
            PH_FETCH0: begin ctrl_d = FETCH0; step_d = 5'd1; end
            PH_FETCH1: begin ctrl_d = FETCH1; step_d = 5'd2; end
            PH_FETCH2: begin ctrl_d = FETCH2; step_d = 5'd3; end
            PH_EXEC: begin
                if (cond_pass) begin
                    ctrl_d = mword[CTRL_W-1:0];
                    if (mword[CTRL_W] || (mword == '0) || (step_q == 5'(LAST_STEP))) begin
                        step_d = 5'd0;
                    end else begin
                        step_d = step_q + 5'd1;
                    end
                end
            end
            default: begin ctrl_d = '0; step_d = '0; end
        endcase
    end

    assign bus.ctrl     = ctrl_q;
    assign bus.step     = step_q;
    assign bus.fetching = (step_q < 5'd3);
endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter CTRL_W, 16, control word width.
REQ-002 Parameter OP_W, 8, opcode width; microcode holds 2**OP_W instructions.
REQ-003 Parameter STEPS, 4, execute microsteps per instruction (1..16); SW = clog2(STEPS) (minimum 1).
REQ-004 Parameters FETCH0/FETCH1/FETCH2, CTRL_W bits each, default PCO|MAI|PCS, MO|II, PCO|MAI|PCS, fetch control words.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 zf  input  1  ALU zero flag.
REQ-008 cf  input  1  ALU carry flag.
REQ-009 ireg  input  OP_W  current opcode from the instruction register.
REQ-010 hold  input  1  freezes the sequencer when high.
REQ-011 uc_we  input  1  microcode write strobe.
REQ-012 uc_addr  input  OP_W+SW  write address {opcode, step index}.
REQ-013 uc_wdata  input  CTRL_W+3  microword {cond[1:0], last, ctrl[CTRL_W-1:0]}.
REQ-014 ctrl  output  CTRL_W  registered control word.
REQ-015 step  output  5  current sequencer step.
REQ-016 fetching  output  1  high while step < 3.

Function
REQ-017 Steps 0,1,2 shall be fetch; steps 3..STEPS+2 shall be execute.
REQ-018 Each rising edge with hold=0 shall load ctrl with the word for the current step and advance step to the next value.
REQ-019 Fetch steps 0/1/2 shall load FETCH0/FETCH1/FETCH2 and then advance to step+1.
REQ-020 An execute step k shall read microword M = ucode[ireg][k-3].
REQ-021 Cond codes: 00 = always; 01 = pass if zf=1; 10 = pass if cf=1; 11 = pass if zf=0.
REQ-022 Failed cond: ctrl <= 0 and next step = 0 (instruction aborted).
REQ-023 Passed cond: ctrl <= M.ctrl.
REQ-024 Next step shall be 0 if M.last=1, or M is all-zero, or k = STEPS+2; otherwise k+1.
REQ-025 Flags shall be sampled on the same edge that evaluates cond; there is no flag latching inside the block.
REQ-026 hold=1 shall keep step and ctrl unchanged, including mid-execute; the uc_we write still occurs.
REQ-027 uc_we=1 shall write uc_wdata into ucode at uc_addr on the rising edge.
REQ-028 A write to the entry being read on the same edge shall return the old value (read-before-write).
REQ-029 Addresses with step index >= STEPS shall be ignored.
REQ-030 Microcode storage shall initialise to all-zero, so every unwritten opcode behaves as a NOP of one execute step.
REQ-031 Step shall never exceed STEPS+2; any other value shall force next step 0.

Reset
REQ-032 rst=1 shall immediately set ctrl=0, step=0, fetching=1, regardless of clk.
REQ-033 Reset shall not clear microcode contents.
REQ-034 After rst falls, the first rising edge shall load FETCH0.
REQ-035 Reset asserted mid-instruction shall abandon it; there is no partial completion.

Verification (FETCH0=16'h0001, FETCH1=16'h0002, FETCH2=16'h0004, STEPS=4)
REQ-036 Reset release, ireg=0x00 with memory empty -> ctrl sequence 0001, 0002, 0004, 0000, then 0001; step sequence 0,1,2,3,0.
REQ-037 Write op 0x01: words {00,0,8001}, {00,0,4002}, {00,1,2003} -> after fetch, ctrl 8001, 4002, 2003, then fetch restarts.
REQ-038 Op 0x02 step0 = {01,1,0100}; run with zf=0 -> ctrl 0000, step 0; run with zf=1 -> ctrl 0100, then fetch.
REQ-039 Op 0x03 step0 = {10,0,0010}, step1 = {00,1,0020}, cf=1 -> 0010, 0020; pulse hold for 3 cycles between them -> ctrl holds 0010, step holds 4.
REQ-040 Assert rst asynchronously during step 4 of op 0x01 -> ctrl=0 and step=0 before the next edge, and op 0x01 microcode intact on rerun.
REQ-041 Write op 0x01 step0 on the same edge that reads it -> that cycle outputs the old 8001; the next execution outputs the new value.
